// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit: lane placement, misaligned split, load extension
module load_store_unit #(
    parameter int BUS_BYTES        = 4,
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                               clk,
    input  logic                               sync_rst,
    input  logic                               clk_en,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_write,
    input  logic [2:0]                         req_fn3,
    input  logic [ADDR_W-1:0]                  req_addr,
    input  logic [31:0]                        req_wdata,
    input  logic                               req_lock,
    output logic                               mem_valid,
    input  logic                               mem_ready,
    output logic [ADDR_W-$clog2(BUS_BYTES)-1:0] mem_addr,
    output logic                               mem_write,
    output logic [8*BUS_BYTES-1:0]             mem_wdata,
    output logic [BUS_BYTES-1:0]               mem_mask,
    input  logic [8*BUS_BYTES-1:0]             mem_rdata,
    output logic                               mem_lock,
    output logic                               resp_valid,
    output logic [31:0]                        resp_data,
    output logic                               resp_fault
);
    localparam int OFF_W = $clog2(BUS_BYTES);
    localparam int WA_W  = ADDR_W - OFF_W;
    localparam int DW    = 8 * BUS_BYTES;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t           state;
    logic             r_write;
    logic [2:0]       r_fn3;
    logic [OFF_W-1:0] r_off;
    logic [31:0]      r_wdata;
    logic             r_cross;
    logic [31:0]      r_acc;

    int          a_off, a_n, r_off_i, r_n;
    logic        a_cross, a_fault;
    logic [31:0] gathered;

    // Lane carrying request byte k in the given beat, or -1 if that byte is not in this beat.
    function automatic int lane_of(input int off, input int n, input int k, input logic second);
        int pos;
        pos = off + k;
        if (k >= n) return -1;
        if (second) return (pos >= BUS_BYTES) ? pos - BUS_BYTES : -1;
        return (pos < BUS_BYTES) ? pos : -1;
    endfunction

    function automatic logic [BUS_BYTES-1:0] beat_mask(input int off, input int n, input logic second);
        logic [BUS_BYTES-1:0] m;
        int lane;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            lane = lane_of(off, n, k, second);
            if (lane >= 0) m = m | (BUS_BYTES'(1) << (BUS_BYTES - 1 - lane));
        end
        return m;
    endfunction

    function automatic logic [DW-1:0] beat_data(input int off, input int n, input logic [31:0] wd,
                                                input logic second);
        logic [DW-1:0] d;
        int lane;
        d = '0;
        for (int k = 0; k < 4; k++) begin
            lane = lane_of(off, n, k, second);
            if (lane >= 0) d = d | (DW'(8'(wd >> (8 * k))) << (8 * (BUS_BYTES - 1 - lane)));
        end
        return d;
    endfunction

    function automatic logic [31:0] gather(input logic [31:0] acc, input logic [DW-1:0] rd,
                                           input int off, input int n, input logic second);
        logic [31:0] v;
        int lane;
        v = acc;
        for (int k = 0; k < 4; k++) begin
            lane = lane_of(off, n, k, second);
            if (lane >= 0) v = v | (32'(8'(rd >> (8 * (BUS_BYTES - 1 - lane)))) << (8 * k));
        end
        return v;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] fn3);
        case (fn3[1:0])
            2'd0:    return fn3[2] ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            2'd1:    return fn3[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    always_comb begin
        a_off    = int'(req_addr[OFF_W-1:0]);
        a_n      = 1 << req_fn3[1:0];
        a_cross  = (a_off + a_n) > BUS_BYTES;
        a_fault  = (req_fn3[1:0] == 2'd3) || (req_write && req_fn3[2]) ||
                   (!ALLOW_MISALIGNED && a_cross);
        r_off_i  = int'(r_off);
        r_n      = 1 << r_fn3[1:0];
        gathered = gather(r_acc, mem_rdata, r_off_i, r_n, state == BEAT1);
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_write  <= 1'b0;
            mem_wdata  <= '0;
            mem_mask   <= '0;
            mem_lock   <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_fault <= 1'b0;
            r_write    <= 1'b0;
            r_fn3      <= '0;
            r_off      <= '0;
            r_wdata    <= '0;
            r_cross    <= 1'b0;
            r_acc      <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    r_write   <= req_write;
                    r_fn3     <= req_fn3;
                    r_off     <= req_addr[OFF_W-1:0];
                    r_wdata   <= req_wdata;
                    r_cross   <= a_cross;
                    r_acc     <= '0;
                    req_ready <= 1'b0;
                    if (a_fault) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b1;
                        resp_data  <= '0;
                    end else begin
                        state     <= BEAT0;
                        mem_valid <= 1'b1;
                        mem_lock  <= req_lock || a_cross;
                        mem_addr  <= req_addr[ADDR_W-1:OFF_W];
                        mem_write <= req_write;
                        mem_mask  <= beat_mask(a_off, a_n, 1'b0);
                        mem_wdata <= req_write ? beat_data(a_off, a_n, req_wdata, 1'b0) : '0;
                    end
                end
                BEAT0, BEAT1: if (mem_ready) begin
                    if (state == BEAT0 && r_cross) begin
                        state     <= BEAT1;
                        r_acc     <= gathered;
                        mem_addr  <= mem_addr + WA_W'(1);
                        mem_mask  <= beat_mask(r_off_i, r_n, 1'b1);
                        mem_wdata <= r_write ? beat_data(r_off_i, r_n, r_wdata, 1'b1) : '0;
                    end else begin
                        state      <= RESP;
                        mem_valid  <= 1'b0;
                        mem_lock   <= 1'b0;
                        mem_mask   <= '0;
                        mem_wdata  <= '0;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_data  <= r_write ? 32'd0 : extend(gathered, r_fn3);
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_data  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized and directed bench for load_store_unit against a byte-memory model
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        sync_rst, clk_en;
    logic        req_valid, req_valid_na, req_valid8;
    logic        req_write, req_lock;
    logic [2:0]  req_fn3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        one_b = 1'b1;
    logic [31:0] zero32 = 32'd0;
    logic [63:0] rdata8 = 64'h0123456789ABCDEF;

    logic        req_ready, mem_valid, mem_write, mem_lock, resp_valid, resp_fault;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, resp_data;
    logic [3:0]  mem_mask;

    logic        req_ready_na, mem_valid_na, mem_write_na, mem_lock_na, resp_valid_na, resp_fault_na;
    logic [29:0] mem_addr_na;
    logic [31:0] mem_wdata_na, resp_data_na;
    logic [3:0]  mem_mask_na;

    logic        req_ready8, mem_valid8, mem_write8, mem_lock8, resp_valid8, resp_fault8;
    logic [28:0] mem_addr8;
    logic [63:0] mem_wdata8;
    logic [7:0]  mem_mask8;
    logic [31:0] resp_data8;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rmem [0:255];
    logic [7:0]  wmem [0:255];
    logic [29:0] q_addr [$];
    logic [3:0]  q_mask [$];
    logic [31:0] q_wdata [$];
    logic        q_lock [$];

    load_store_unit #(.BUS_BYTES(4), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_fn3(req_fn3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_lock(req_lock),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata), .mem_lock(mem_lock),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault));

    load_store_unit #(.BUS_BYTES(4), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_na (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
        .req_valid(req_valid_na), .req_ready(req_ready_na), .req_write(req_write), .req_fn3(req_fn3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_lock(req_lock),
        .mem_valid(mem_valid_na), .mem_ready(one_b), .mem_addr(mem_addr_na), .mem_write(mem_write_na),
        .mem_wdata(mem_wdata_na), .mem_mask(mem_mask_na), .mem_rdata(zero32), .mem_lock(mem_lock_na),
        .resp_valid(resp_valid_na), .resp_data(resp_data_na), .resp_fault(resp_fault_na));

    load_store_unit #(.BUS_BYTES(8), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut8 (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
        .req_valid(req_valid8), .req_ready(req_ready8), .req_write(req_write), .req_fn3(req_fn3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_lock(req_lock),
        .mem_valid(mem_valid8), .mem_ready(one_b), .mem_addr(mem_addr8), .mem_write(mem_write8),
        .mem_wdata(mem_wdata8), .mem_mask(mem_mask8), .mem_rdata(rdata8), .mem_lock(mem_lock8),
        .resp_valid(resp_valid8), .resp_data(resp_data8), .resp_fault(resp_fault8));

    always #5 clk = ~clk;

    // Bus slave: reads come from rmem, accepted store lanes land in wmem (lane 0 = lowest address).
    always_comb begin
        mem_rdata = '0;
        for (int j = 0; j < 4; j++) mem_rdata[8*(3-j) +: 8] = rmem[{mem_addr[5:0], 2'(j)}];
    end

    always @(posedge clk) begin
        if (!sync_rst && clk_en && mem_valid && mem_ready) begin
            q_addr.push_back(mem_addr);
            q_mask.push_back(mem_mask);
            q_wdata.push_back(mem_wdata);
            q_lock.push_back(mem_lock);
            for (int j = 0; j < 4; j++)
                if (mem_mask[3-j]) wmem[{mem_addr[5:0], 2'(j)}] <= mem_wdata[8*(3-j) +: 8];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic run_req(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                           input logic lk, input bit stall, output logic [31:0] rd, output logic flt,
                           output int lat, output logic post_rv, output logic post_rdy);
        req_valid = 1'b1; req_write = w; req_fn3 = f; req_addr = a; req_wdata = wd; req_lock = lk;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom); req_fn3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_lock = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 64) begin
            mem_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) lat = -1;
        rd = resp_data; flt = resp_fault; mem_ready = 1'b1;
        @(negedge clk);
        post_rv = resp_valid; post_rdy = req_ready;
    endtask

    task automatic test_reset();
        sync_rst = 1'b1; clk_en = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if ({mem_valid, mem_lock, resp_valid, resp_fault} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {mem_valid, mem_lock, resp_valid, resp_fault}); end
        checks++; if ({resp_data, mem_wdata, mem_mask} !== 68'd0) begin
            errors++; $display("FAIL reset_data got %h/%h/%b want 0", resp_data, mem_wdata, mem_mask); end
        sync_rst = 1'b0;
    endtask

    task automatic test_store_word();
        logic [31:0] rd; logic flt, prv, prdy; int lat, b;
        b = q_addr.size();
        run_req(1'b1, 3'd2, 32'h100, 32'h11223344, 1'b0, 1'b0, rd, flt, lat, prv, prdy);
        checks++; if (lat !== 2 || flt !== 1'b0 || rd !== 32'd0) begin
            errors++; $display("FAIL sw_resp lat %0d fault %b data %h want 2 0 0", lat, flt, rd); end
        checks++; if (q_addr.size() - b !== 1 || q_addr[b] !== 30'h40 || q_wdata[b] !== 32'h44332211 || q_mask[b] !== 4'b1111) begin
            errors++; $display("FAIL sw_beat beats %0d addr %h wdata %h mask %b want 1 40 44332211 1111",
                                q_addr.size() - b, q_addr[b], q_wdata[b], q_mask[b]); end
        checks++; if (prv !== 1'b0 || prdy !== 1'b1) begin
            errors++; $display("FAIL sw_after resp_valid %b req_ready %b want 0 1", prv, prdy); end
    endtask

    task automatic test_split_load();
        logic [31:0] rd; logic flt, prv, prdy; int lat, b;
        rmem[0] = 8'h00; rmem[1] = 8'h00; rmem[2] = 8'h00; rmem[3] = 8'hAB;
        rmem[4] = 8'hCD; rmem[5] = 8'h00; rmem[6] = 8'h00; rmem[7] = 8'h00;
        b = q_addr.size();
        run_req(1'b0, 3'd1, 32'h103, 32'd0, 1'b0, 1'b0, rd, flt, lat, prv, prdy);
        checks++; if (rd !== 32'hFFFFCDAB || lat !== 3 || flt !== 1'b0) begin
            errors++; $display("FAIL lh_split data %h lat %0d fault %b want ffffcdab 3 0", rd, lat, flt); end
        checks++; if (q_addr.size() - b !== 2) begin
            errors++; $display("FAIL lh_split_beats got %0d want 2", q_addr.size() - b); end
        else begin
            checks++; if (q_addr[b] !== 30'h40 || q_addr[b+1] !== 30'h41 || q_mask[b] !== 4'b0001 || q_mask[b+1] !== 4'b1000) begin
                errors++; $display("FAIL lh_split_addr %h/%h mask %b/%b want 40/41 0001/1000",
                                    q_addr[b], q_addr[b+1], q_mask[b], q_mask[b+1]); end
            checks++; if (q_lock[b] !== 1'b1 || q_lock[b+1] !== 1'b1) begin
                errors++; $display("FAIL lh_split_lock got %b%b want 11", q_lock[b], q_lock[b+1]); end
        end
    endtask

    task automatic test_byte_load();
        logic [31:0] rd; logic flt, prv, prdy; int lat, b;
        rmem[0] = 8'h00; rmem[1] = 8'h11; rmem[2] = 8'hF0; rmem[3] = 8'h00;
        b = q_addr.size();
        run_req(1'b0, 3'd4, 32'h102, 32'd0, 1'b0, 1'b0, rd, flt, lat, prv, prdy);
        checks++; if (rd !== 32'h000000F0 || q_mask[b] !== 4'b0010) begin
            errors++; $display("FAIL lbu data %h mask %b want 000000f0 0010", rd, q_mask[b]); end
        run_req(1'b0, 3'd0, 32'h102, 32'd0, 1'b0, 1'b0, rd, flt, lat, prv, prdy);
        checks++; if (rd !== 32'hFFFFFFF0) begin
            errors++; $display("FAIL lb data %h want fffffff0", rd); end
    endtask

    task automatic test_fault();
        logic [31:0] rd; logic flt, prv, prdy; int lat, b;
        b = q_addr.size();
        run_req(1'b1, 3'd3, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, rd, flt, lat, prv, prdy);
        checks++; if (lat !== 1 || flt !== 1'b1 || rd !== 32'd0 || q_addr.size() !== b) begin
            errors++; $display("FAIL fault_size lat %0d fault %b data %h beats %0d want 1 1 0 0", lat, flt, rd, q_addr.size() - b); end
        run_req(1'b1, 3'd4, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, rd, flt, lat, prv, prdy);
        checks++; if (lat !== 1 || flt !== 1'b1 || q_addr.size() !== b) begin
            errors++; $display("FAIL fault_ustore lat %0d fault %b beats %0d want 1 1 0", lat, flt, q_addr.size() - b); end
        req_valid_na = 1'b1; req_write = 1'b1; req_fn3 = 3'd2; req_addr = 32'h101; req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid_na = 1'b0;
        checks++; if (resp_valid_na !== 1'b1 || resp_fault_na !== 1'b1 || resp_data_na !== 32'd0 || mem_valid_na !== 1'b0) begin
            errors++; $display("FAIL fault_misaligned valid %b fault %b data %h mem_valid %b want 1 1 0 0",
                                resp_valid_na, resp_fault_na, resp_data_na, mem_valid_na); end
        @(negedge clk);
        req_valid_na = 1'b1; req_write = 1'b0; req_fn3 = 3'd2; req_addr = 32'h104;
        @(negedge clk);
        req_valid_na = 1'b0;
        checks++; if (mem_valid_na !== 1'b1 || mem_mask_na !== 4'b1111) begin
            errors++; $display("FAIL na_aligned_beat valid %b mask %b want 1 1111", mem_valid_na, mem_mask_na); end
        @(negedge clk);
        checks++; if (resp_valid_na !== 1'b1 || resp_fault_na !== 1'b0) begin
            errors++; $display("FAIL na_aligned_resp valid %b fault %b want 1 0", resp_valid_na, resp_fault_na); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [29:0] a0; logic [31:0] w0; logic [3:0] m0;
        mem_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_fn3 = 3'd0; req_addr = 32'h101; req_wdata = 32'hAABBCC5A; req_lock = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; req_wdata = 32'h0;
        a0 = mem_addr; w0 = mem_wdata; m0 = mem_mask;
        checks++; if (mem_valid !== 1'b1 || a0 !== 30'h40 || w0 !== 32'h005A0000 || m0 !== 4'b0100) begin
            errors++; $display("FAIL stall_beat valid %b addr %h wdata %h mask %b want 1 40 005a0000 0100", mem_valid, a0, w0, m0); end
        for (int i = 0; i < 3; i++) begin
            clk_en = (i != 1); mem_ready = (i == 1);
            @(negedge clk);
            checks++; if (mem_valid !== 1'b1 || mem_addr !== a0 || mem_wdata !== w0 || mem_mask !== m0 || resp_valid !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d valid %b addr %h wdata %h mask %b resp %b", i, mem_valid, mem_addr, mem_wdata, mem_mask, resp_valid); end
        end
        clk_en = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || mem_valid !== 1'b0) begin
            errors++; $display("FAIL stall_resp resp %b mem_valid %b want 1 0", resp_valid, mem_valid); end
        clk_en = 1'b0;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL resp_hold_disabled got %b want 1", resp_valid); end
        clk_en = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || wmem[1] !== 8'h5A) begin
            errors++; $display("FAIL stall_done resp %b ready %b byte %h want 0 1 5a", resp_valid, req_ready, wmem[1]); end
    endtask

    task automatic test_bus8();
        req_valid8 = 1'b1; req_write = 1'b0; req_fn3 = 3'd2; req_addr = 32'h0C;
        @(negedge clk);
        req_valid8 = 1'b0;
        checks++; if (mem_valid8 !== 1'b1 || mem_mask8 !== 8'b00001111 || mem_addr8 !== 29'd1) begin
            errors++; $display("FAIL bus8_beat valid %b mask %b addr %h want 1 00001111 1", mem_valid8, mem_mask8, mem_addr8); end
        @(negedge clk);
        checks++; if (resp_valid8 !== 1'b1 || resp_data8 !== 32'hEFCDAB89 || resp_fault8 !== 1'b0) begin
            errors++; $display("FAIL bus8_resp valid %b data %h fault %b want 1 efcdab89 0", resp_valid8, resp_data8, resp_fault8); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic flt, prv, prdy; int lat, b;
        req_valid = 1'b1; req_write = 1'b0; req_fn3 = 3'd1; req_addr = 32'h103; req_lock = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 30'h41 || mem_lock !== 1'b1) begin
            errors++; $display("FAIL rst_mid_beat1 valid %b addr %h lock %b want 1 41 1", mem_valid, mem_addr, mem_lock); end
        mem_ready = 1'b0; sync_rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid valid %b resp %b ready %b want 0 0 1", mem_valid, resp_valid, req_ready); end
        sync_rst = 1'b0; mem_ready = 1'b1;
        b = q_addr.size();
        run_req(1'b1, 3'd2, 32'h200, 32'hCAFEF00D, 1'b0, 1'b0, rd, flt, lat, prv, prdy);
        checks++; if (lat !== 2 || flt !== 1'b0 || q_addr.size() - b !== 1 || q_addr[b] !== 30'h80) begin
            errors++; $display("FAIL rst_mid_next lat %0d fault %b beats %0d addr %h want 2 0 1 80", lat, flt, q_addr.size() - b, q_addr[b]); end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd, ev, obs; logic [2:0] f; logic w, lk, flt, prv, prdy, fe, split;
        int n, lat, b, nb, elat; bit stall; logic lanes_ok, lock_ok, addr_ok;
        for (int i = 0; i < 300; i++) begin
            w  = 1'($urandom);
            f[1:0] = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            f[2]   = w ? ($urandom_range(0, 9) == 0) : 1'($urandom);
            a  = (i % 25 == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
            wd = $urandom; lk = 1'($urandom); stall = (i % 2 == 1);
            b  = q_addr.size();
            run_req(w, f, a, wd, lk, stall, rd, flt, lat, prv, prdy);
            n     = 1 << f[1:0];
            fe    = (f[1:0] == 2'd3) || (w && f[2]);
            split = !fe && ((a % 4) + n > 4);
            elat  = fe ? 1 : (split ? 3 : 2);
            nb    = q_addr.size() - b;
            checks++; if (flt !== fe || nb !== (fe ? 0 : (split ? 2 : 1))) begin
                errors++; $display("FAIL rnd%0d_fault fault %b beats %0d want %b %0d", i, flt, nb, fe, fe ? 0 : (split ? 2 : 1)); end
            checks++; if (stall ? (lat < elat) : (lat !== elat)) begin
                errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, elat); end
            checks++; if (prv !== 1'b0 || prdy !== 1'b1) begin
                errors++; $display("FAIL rnd%0d_after resp %b ready %b want 0 1", i, prv, prdy); end
            if (!fe && nb > 0) begin
                addr_ok = (q_addr[b] === a[31:2]) && (nb < 2 || q_addr[b+1] === a[31:2] + 30'd1);
                lock_ok = 1'b1; lanes_ok = 1'b1;
                for (int j = 0; j < nb; j++) begin
                    if (q_lock[b+j] !== (lk || split)) lock_ok = 1'b0;
                    for (int l = 0; l < 4; l++)
                        if (!q_mask[b+j][3-l] && q_wdata[b+j][8*(3-l) +: 8] !== 8'h00) lanes_ok = 1'b0;
                end
                checks++; if (!addr_ok || !lock_ok || !lanes_ok) begin
                    errors++; $display("FAIL rnd%0d_bus addr_ok %b lock_ok %b lanes_ok %b (addr %h lk %b)", i, addr_ok, lock_ok, lanes_ok, a, lk); end
            end
            ev = 32'd0; obs = 32'd0;
            if (!fe && w) begin
                for (int k = 0; k < n; k++) begin
                    ev  = ev | (wd & (32'hFF << (8 * k)));
                    obs = obs | (32'(wmem[8'(a + 32'(k))]) << (8 * k));
                end
                checks++; if (obs !== ev || rd !== 32'd0) begin
                    errors++; $display("FAIL rnd%0d_store mem %h resp %h want %h 0 (addr %h fn3 %0d)", i, obs, rd, ev, a, f); end
            end else if (!fe) begin
                for (int k = 0; k < n; k++) ev = ev | (32'(rmem[8'(a + 32'(k))]) << (8 * k));
                if (!f[2] && n < 4 && ev[8*n-1]) ev = ev | (32'hFFFFFFFF << (8 * n));
                checks++; if (rd !== ev) begin
                    errors++; $display("FAIL rnd%0d_load got %h want %h (addr %h fn3 %0d)", i, rd, ev, a, f); end
            end else begin
                checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rnd%0d_fault_data got %h want 0", i, rd); end
            end
        end
    endtask

    initial begin
        sync_rst = 1'b1; clk_en = 1'b1;
        req_valid = 1'b0; req_valid_na = 1'b0; req_valid8 = 1'b0;
        req_write = 1'b0; req_fn3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; req_lock = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 256; i++) rmem[i] = 8'($urandom);
        @(negedge clk);
        test_reset();
        test_store_word();
        test_split_load();
        test_byte_load();
        test_fault();
        test_stall();
        test_bus8();
        test_reset_mid();
        for (int i = 0; i < 256; i++) rmem[i] = 8'($urandom);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Parametrised memory access unit that sits between the execute stage and the memory bus, and is the successor of the single-cycle store adjuster.
- Accepts one load/store request at a time from execute.
- Drives a valid/ready memory bus of configurable width.
- Splits misaligned accesses into two bus beats.
- Returns load data sign- or zero-extended and aligned for writeback.
- Byte-lane convention is unchanged: lane 0 (most significant bus byte) is the lowest address; register LSB goes to the lowest address.

Parameters:
BUS_BYTES, 4, bus width in bytes; legal values 4 or 8.
ADDR_W, 32, byte address width.
ALLOW_MISALIGNED, 1, 1 = split accesses that cross a bus word into two beats; 0 = fault without a bus access.

Ports:
clk  in  1  clock
sync_rst  in  1  synchronous active-high reset
clk_en  in  1  global enable; when 0, all state and registered outputs hold
req_valid  in  1  request present
req_ready  out  1  unit can accept; 1 only in IDLE
req_write  in  1  1 = store
req_fn3  in  3  funct3: [1:0] size (0 = byte, 1 = half, 2 = word), [2] = unsigned load
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (rs2)
req_lock  in  1  lock the bus for the whole access
mem_valid  out  1  bus beat valid
mem_ready  in  1  bus accepts the beat (sampled only when clk_en = 1)
mem_addr  out  ADDR_W-$clog2(BUS_BYTES)  bus word address
mem_write  out  1  write = 1
mem_wdata  out  8*BUS_BYTES  lane-positioned store data
mem_mask  out  BUS_BYTES  byte enable; MSB = lane 0
mem_rdata  in  8*BUS_BYTES  read data, valid when mem_valid && mem_ready
mem_lock  out  1  bus lock
resp_valid  out  1  one-cycle pulse: access complete
resp_data  out  32  extended load data (0 for stores and faults)
resp_fault  out  1  qualifies resp_valid: illegal size or disallowed misalignment

Behaviour:
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- Reset: state = IDLE. mem_valid, mem_lock, resp_valid, resp_fault = 0. resp_data, mem_wdata, mem_mask = 0. req_ready = 1.
- Acceptance: a request is accepted on req_valid && req_ready && clk_en. All request fields are registered at acceptance; later changes to req_* are ignored.
- Fault check at acceptance:
  - size = 3, or a store with fn3[2] = 1, is a fault.
  - offset + size_bytes > BUS_BYTES with ALLOW_MISALIGNED = 0 is a fault.
  - On a fault: IDLE -> RESP, no bus beat, resp_fault = 1.
- Otherwise IDLE -> BEAT0. mem_valid is asserted the cycle after acceptance.
- BEAT0:
  - mem_addr = addr >> log2(BUS_BYTES).
  - Mask covers bytes offset .. min(offset + n - 1, BUS_BYTES - 1).
  - On mem_ready: go to BEAT1 if the access crosses the word, else RESP.
- BEAT1:
  - mem_addr = BEAT0 word address + 1; wraps modulo 2^(ADDR_W - log2 BUS_BYTES).
  - Mask covers the remaining bytes from lane 0.
  - On mem_ready: go to RESP.
- Bus stability: while mem_valid && !mem_ready, all mem_* outputs are held stable.
- Store lane placement: byte k of req_wdata (k = 0 is the LSB) goes to address addr + k. Unmasked lanes = 0.
- Load assembly: the byte read from address addr + k becomes resp_data byte k. Bits above size are sign-extended from the top loaded bit when fn3[2] = 0, zero-extended when fn3[2] = 1.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. req_ready rises in the IDLE cycle after RESP.
- Latency with mem_ready tied high: aligned access accepted at T -> beat at T+1, resp_valid at T+2. Split access -> resp_valid at T+3. Fault -> resp_valid at T+1.
- mem_lock:
  - Asserted from BEAT0 entry through the last beat when req_lock is set.
  - Always asserted across both beats of a split access, so the pair is atomic.
  - Deasserted in RESP.
- clk_en = 0: the FSM freezes, mem_ready is ignored, and outputs hold. A held resp_valid stays asserted until the next enabled cycle.
- sync_rst mid-access: the access is abandoned. Next cycle mem_valid = 0, resp_valid = 0, state = IDLE. No response is issued.
- BUS_BYTES = 8: a word at offset 4 is a single beat with mask 8'b00001111.

Test Plan:
- Store word, BUS_BYTES = 4, addr 0x100, wdata 0x11223344, mem_ready = 1 -> one beat: mem_addr 0x40, mem_wdata 0x44332211, mask 1111. resp_valid at T+2, resp_fault = 0.
- Load half signed at 0x103, beat0 rdata 0x000000AB, beat1 rdata 0xCD000000 -> beats at word addresses 0x40 (mask 0001) then 0x41 (mask 1000). mem_lock high on both beats. resp_data 0xFFFFCDAB at T+3.
- Load byte unsigned at 0x102, rdata 0x0011F000 -> mask 0010, resp_data 0x000000F0. Same access with fn3 = 0 (signed) -> 0xFFFFFFF0.
- Store with fn3 = 3 -> no mem_valid, resp_valid + resp_fault at T+1, resp_data 0. Word at 0x101 with ALLOW_MISALIGNED = 0 -> same fault response.
- Store byte at 0x101 with mem_ready low for 3 cycles and clk_en low for 1 cycle mid-stall -> mem_addr, mem_wdata 0x00XX0000 and mask 0100 held unchanged. resp_valid one cycle after the first enabled mem_ready.
- sync_rst asserted during BEAT1 of a split load -> mem_valid low next cycle, no resp_valid. A new request is accepted immediately after reset is released.
